// File: rtl/tl_rx_fc_credit_tracker.sv
// Receive-side flow-control credit tracker: per-class CREDITS_ALLOCATED counters
// plus an UpdateFC request arbiter with a periodic refresh timer.
module tl_rx_fc_credit_tracker #(
  parameter int unsigned FC_DATA_CREDS_WIDTH = 16,
  parameter int unsigned FC_HDR_CREDS_WIDTH  = 12,
  parameter int unsigned P_HDR_INIT          = 32,
  parameter int unsigned P_DATA_INIT         = 512,
  parameter int unsigned NP_HDR_INIT         = 32,
  parameter int unsigned NP_DATA_INIT        = 0,
  parameter int unsigned CPL_HDR_INIT        = 0,
  parameter int unsigned CPL_DATA_INIT       = 0,
  parameter logic [1:0]  FC_SCALE            = 2'b01,
  parameter int unsigned UPDATE_PERIOD       = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           free_valid,
  input  logic [1:0]                     free_typ,
  input  logic                           free_hdr,
  input  logic [FC_DATA_CREDS_WIDTH-1:0] free_data_creds,
  input  logic                           updatefc_ack,
  output logic [FC_HDR_CREDS_WIDTH-1:0]  p_hdr_creds_reg,
  output logic [FC_HDR_CREDS_WIDTH-1:0]  np_hdr_creds_reg,
  output logic [FC_HDR_CREDS_WIDTH-1:0]  cpl_hdr_creds_reg,
  output logic [FC_DATA_CREDS_WIDTH-1:0] p_data_creds_reg,
  output logic [FC_DATA_CREDS_WIDTH-1:0] np_data_creds_reg,
  output logic [FC_DATA_CREDS_WIDTH-1:0] cpl_data_creds_reg,
  output logic [1:0]                     p_hdr_scale_reg,
  output logic [1:0]                     p_data_scale_reg,
  output logic [1:0]                     np_hdr_scale_reg,
  output logic [1:0]                     np_data_scale_reg,
  output logic [1:0]                     cpl_hdr_scale_reg,
  output logic [1:0]                     cpl_data_scale_reg,
  output logic                           updatefc_req,
  output logic [1:0]                     updatefc_typ,
  output logic [FC_HDR_CREDS_WIDTH-1:0]  updatefc_hdr_creds,
  output logic [FC_DATA_CREDS_WIDTH-1:0] updatefc_data_creds
);

  localparam int unsigned NCLS  = 3;
  localparam int unsigned HW    = FC_HDR_CREDS_WIDTH;
  localparam int unsigned DW    = FC_DATA_CREDS_WIDTH;
  localparam int unsigned TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDATE_PERIOD - 1);

  localparam logic [1:0] TYP_P   = 2'b00;
  localparam logic [1:0] TYP_NP  = 2'b01;
  localparam logic [1:0] TYP_CPL = 2'b10;

  // A field advertised with INIT 0 is infinite and never tracked.
  localparam logic [NCLS-1:0] HDR_FIN  = {CPL_HDR_INIT != 0, NP_HDR_INIT != 0, P_HDR_INIT != 0};
  localparam logic [NCLS-1:0] DATA_FIN = {CPL_DATA_INIT != 0, NP_DATA_INIT != 0, P_DATA_INIT != 0};

  localparam logic [NCLS-1:0][HW-1:0] HDR_INIT_V =
    {HW'(CPL_HDR_INIT), HW'(NP_HDR_INIT), HW'(P_HDR_INIT)};
  localparam logic [NCLS-1:0][DW-1:0] DATA_INIT_V =
    {DW'(CPL_DATA_INIT), DW'(NP_DATA_INIT), DW'(P_DATA_INIT)};

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t                   state_q, state_d;
  logic [NCLS-1:0][HW-1:0]  hdr_cnt_q;
  logic [NCLS-1:0][DW-1:0]  data_cnt_q;
  logic [NCLS-1:0]          pend_q;
  logic [TMR_W-1:0]         tmr_q;

  logic [NCLS-1:0] rel_cls_c;
  logic [NCLS-1:0] hdr_inc_c;
  logic [NCLS-1:0] data_inc_c;
  logic [NCLS-1:0] rel_set_c;
  logic [NCLS-1:0] tmr_set_c;
  logic [NCLS-1:0] sel_oh_c;
  logic [NCLS-1:0] ack_clr_c;

  logic          req_d;
  logic [1:0]    typ_d;
  logic [HW-1:0] hdr_d;
  logic [DW-1:0] data_d;

  // Release decode; class 11 maps to no class at all.
  always_comb begin
    rel_cls_c = '0;
    if (free_valid) begin
      case (free_typ)
        TYP_P:   rel_cls_c = 3'b001;
        TYP_NP:  rel_cls_c = 3'b010;
        TYP_CPL: rel_cls_c = 3'b100;
        default: rel_cls_c = '0;
      endcase
    end
  end

  assign hdr_inc_c  = rel_cls_c & HDR_FIN & {NCLS{free_hdr}};
  assign data_inc_c = rel_cls_c & DATA_FIN & {NCLS{free_data_creds != '0}};
  assign rel_set_c  = hdr_inc_c | data_inc_c;
  assign tmr_set_c  = (tmr_q == TMR_LAST) ? (HDR_FIN | DATA_FIN) : '0;

  // One-hot of the class currently being advertised.
  always_comb begin
    sel_oh_c = '0;
    case (updatefc_typ)
      TYP_P:   sel_oh_c = 3'b001;
      TYP_NP:  sel_oh_c = 3'b010;
      TYP_CPL: sel_oh_c = 3'b100;
      default: sel_oh_c = '0;
    endcase
  end

  assign ack_clr_c = ((state_q == ST_REQ) && updatefc_ack) ? sel_oh_c : '0;

  // Allocated counters wrap modulo their width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_cnt_q  <= HDR_INIT_V;
      data_cnt_q <= DATA_INIT_V;
    end else begin
      for (int unsigned c = 0; c < NCLS; c++) begin
        if (hdr_inc_c[c]) hdr_cnt_q[c] <= hdr_cnt_q[c] + HW'(1);
        if (data_inc_c[c]) data_cnt_q[c] <= data_cnt_q[c] + free_data_creds;
      end
    end
  end

  // Refresh timer and pending flags; a same-cycle set beats the ack clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      pend_q <= '0;
    end else begin
      tmr_q  <= (tmr_q == TMR_LAST) ? '0 : tmr_q + TMR_W'(1);
      pend_q <= (pend_q & ~ack_clr_c) | rel_set_c | tmr_set_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= ST_IDLE;
      updatefc_req        <= 1'b0;
      updatefc_typ        <= 2'b00;
      updatefc_hdr_creds  <= '0;
      updatefc_data_creds <= '0;
    end else begin
      state_q             <= state_d;
      updatefc_req        <= req_d;
      updatefc_typ        <= typ_d;
      updatefc_hdr_creds  <= hdr_d;
      updatefc_data_creds <= data_d;
    end
  end

  // Arbiter: fixed priority P > NP > CPL, payload frozen while requesting.
  always_comb begin
    state_d = state_q;
    req_d   = updatefc_req;
    typ_d   = updatefc_typ;
    hdr_d   = updatefc_hdr_creds;
    data_d  = updatefc_data_creds;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          if (pend_q[0]) begin
            typ_d  = TYP_P;
            hdr_d  = hdr_cnt_q[0];
            data_d = data_cnt_q[0];
          end else if (pend_q[1]) begin
            typ_d  = TYP_NP;
            hdr_d  = hdr_cnt_q[1];
            data_d = data_cnt_q[1];
          end else begin
            typ_d  = TYP_CPL;
            hdr_d  = hdr_cnt_q[2];
            data_d = data_cnt_q[2];
          end
        end
      end
      ST_REQ: begin
        if (updatefc_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign p_hdr_creds_reg    = hdr_cnt_q[0];
  assign np_hdr_creds_reg   = hdr_cnt_q[1];
  assign cpl_hdr_creds_reg  = hdr_cnt_q[2];
  assign p_data_creds_reg   = data_cnt_q[0];
  assign np_data_creds_reg  = data_cnt_q[1];
  assign cpl_data_creds_reg = data_cnt_q[2];

  assign p_hdr_scale_reg    = FC_SCALE;
  assign p_data_scale_reg   = FC_SCALE;
  assign np_hdr_scale_reg   = FC_SCALE;
  assign np_data_scale_reg  = FC_SCALE;
  assign cpl_hdr_scale_reg  = FC_SCALE;
  assign cpl_data_scale_reg = FC_SCALE;

endmodule

// File: tb/tb_tl_rx_fc_credit_tracker.sv
// Scoreboard bench: directed releases on a default instance, refresh timer and
// mid-request reset on a second instance with a short update period.
module tb_tl_rx_fc_credit_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default-parameter instance
  logic        rst_n = 1'b0;
  logic        free_valid = 1'b0;
  logic [1:0]  free_typ = 2'b00;
  logic        free_hdr = 1'b0;
  logic [15:0] free_data_creds = 16'd0;
  logic        ack_auto = 1'b0;
  logic        ack_man = 1'b0;
  logic        ack_en = 1'b1;
  logic        updatefc_ack;
  logic [11:0] p_hdr, np_hdr, cpl_hdr;
  logic [15:0] p_data, np_data, cpl_data;
  logic [1:0]  s0, s1, s2, s3, s4, s5;
  logic        updatefc_req;
  logic [1:0]  updatefc_typ;
  logic [11:0] updatefc_hdr_creds;
  logic [15:0] updatefc_data_creds;

  assign updatefc_ack = ack_auto | ack_man;

  tl_rx_fc_credit_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .free_valid(free_valid), .free_typ(free_typ), .free_hdr(free_hdr),
    .free_data_creds(free_data_creds), .updatefc_ack(updatefc_ack),
    .p_hdr_creds_reg(p_hdr), .np_hdr_creds_reg(np_hdr), .cpl_hdr_creds_reg(cpl_hdr),
    .p_data_creds_reg(p_data), .np_data_creds_reg(np_data), .cpl_data_creds_reg(cpl_data),
    .p_hdr_scale_reg(s0), .p_data_scale_reg(s1), .np_hdr_scale_reg(s2),
    .np_data_scale_reg(s3), .cpl_hdr_scale_reg(s4), .cpl_data_scale_reg(s5),
    .updatefc_req(updatefc_req), .updatefc_typ(updatefc_typ),
    .updatefc_hdr_creds(updatefc_hdr_creds), .updatefc_data_creds(updatefc_data_creds)
  );

  // Short-period instance, no releases
  logic        rst8_n = 1'b0;
  logic        free8_valid = 1'b0;
  logic [1:0]  free8_typ = 2'b00;
  logic        free8_hdr = 1'b0;
  logic [15:0] free8_data = 16'd0;
  logic        ack8 = 1'b0;
  logic        ack8_en = 1'b1;
  logic [11:0] p_hdr8, np_hdr8, cpl_hdr8;
  logic [15:0] p_data8, np_data8, cpl_data8;
  logic [1:0]  t0, t1, t2, t3, t4, t5;
  logic        req8;
  logic [1:0]  typ8;
  logic [11:0] hdr8;
  logic [15:0] data8;

  tl_rx_fc_credit_tracker #(.UPDATE_PERIOD(8)) dut8 (
    .clk(clk), .rst_n(rst8_n),
    .free_valid(free8_valid), .free_typ(free8_typ), .free_hdr(free8_hdr),
    .free_data_creds(free8_data), .updatefc_ack(ack8),
    .p_hdr_creds_reg(p_hdr8), .np_hdr_creds_reg(np_hdr8), .cpl_hdr_creds_reg(cpl_hdr8),
    .p_data_creds_reg(p_data8), .np_data_creds_reg(np_data8), .cpl_data_creds_reg(cpl_data8),
    .p_hdr_scale_reg(t0), .p_data_scale_reg(t1), .np_hdr_scale_reg(t2),
    .np_data_scale_reg(t3), .cpl_hdr_scale_reg(t4), .cpl_data_scale_reg(t5),
    .updatefc_req(req8), .updatefc_typ(typ8),
    .updatefc_hdr_creds(hdr8), .updatefc_data_creds(data8)
  );

  logic [29:0] exp_q[$];
  logic [29:0] exp8_q[$];

  function automatic logic [29:0] pk(input logic [1:0] t, input logic [11:0] h,
                                     input logic [15:0] d);
    return {t, h, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Responders: single-cycle ack once a request is seen, when enabled.
  always @(negedge clk) begin
    ack_auto = updatefc_req && ack_en && !ack_auto;
    ack8     = req8 && ack8_en && !ack8;
  end

  // Monitor for the default instance: pop on each new request, check hold while pending.
  logic        prev_a = 1'b0;
  logic [29:0] held_a = '0;
  always @(negedge clk) begin
    if (!rst_n) prev_a = 1'b0;
    else begin
      if (updatefc_req && !prev_a) begin
        held_a = {updatefc_typ, updatefc_hdr_creds, updatefc_data_creds};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got 0x%0h, required no request", held_a);
        end else chk("req_a", 32'(held_a), 32'(exp_q.pop_front()));
      end else if (updatefc_req && prev_a)
        chk("req_a_stable", 32'({updatefc_typ, updatefc_hdr_creds, updatefc_data_creds}),
            32'(held_a));
      prev_a = updatefc_req;
    end
  end

  logic prev8 = 1'b0;
  logic mon8_en = 1'b1;
  always @(negedge clk) begin
    if (!rst8_n) prev8 = 1'b0;
    else begin
      if (req8 && !prev8 && mon8_en) begin
        if (exp8_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req8: got 0x%0h, required no request", {typ8, hdr8, data8});
        end else chk("req8", 32'({typ8, hdr8, data8}), 32'(exp8_q.pop_front()));
      end
      prev8 = req8;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rel(input logic [1:0] t, input logic h, input logic [15:0] d);
    free_valid = 1'b1;
    free_typ = t;
    free_hdr = h;
    free_data_creds = d;
    step();
    free_valid = 1'b0;
    free_typ = 2'b00;
    free_hdr = 1'b0;
    free_data_creds = 16'd0;
  endtask

  task automatic chk_cnt(input string tag, input logic [11:0] ph, input logic [15:0] pd,
                         input logic [11:0] nh, input logic [15:0] nd,
                         input logic [11:0] ch, input logic [15:0] cd);
    chk({tag, "_p_hdr"}, 32'(p_hdr), 32'(ph));
    chk({tag, "_p_data"}, 32'(p_data), 32'(pd));
    chk({tag, "_np_hdr"}, 32'(np_hdr), 32'(nh));
    chk({tag, "_np_data"}, 32'(np_data), 32'(nd));
    chk({tag, "_cpl_hdr"}, 32'(cpl_hdr), 32'(ch));
    chk({tag, "_cpl_data"}, 32'(cpl_data), 32'(cd));
  endtask

  task automatic wait_req_a();
    int k = 0;
    while (!updatefc_req && k < 50) begin
      step();
      k++;
    end
    if (!updatefc_req) fail_now("wait_req_a");
  endtask

  task automatic settle_a();
    int k = 0;
    while ((exp_q.size() != 0 || updatefc_req) && k < 60) begin
      step();
      k++;
    end
    if (exp_q.size() != 0 || updatefc_req) fail_now("settle_a");
    repeat (2) step();
  endtask

  task automatic settle_8();
    int k = 0;
    while ((exp8_q.size() != 0 || req8) && k < 60) begin
      step();
      k++;
    end
    if (exp8_q.size() != 0 || req8) fail_now("settle_8");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk_cnt("reset", 12'd32, 16'd512, 12'd32, 16'd0, 12'd0, 16'd0);
    chk("reset_req", 32'(updatefc_req), 32'd0);
    chk("reset_typ_creds", 32'({updatefc_typ, updatefc_hdr_creds, updatefc_data_creds}), 32'd0);
    chk("scale", 32'({s0, s1, s2, s3, s4, s5}), 32'h555);

    // Basic P release and its UpdateFC
    exp_q.push_back(pk(2'd0, 12'd33, 16'd516));
    rel(2'd0, 1'b1, 16'd4);
    chk_cnt("free_p", 12'd33, 16'd516, 12'd32, 16'd0, 12'd0, 16'd0);
    settle_a();

    // Held request stays stable while P and NP counters move; NP follows after ack
    ack_en = 1'b0;
    exp_q.push_back(pk(2'd0, 12'd34, 16'd516));
    rel(2'd0, 1'b1, 16'd0);
    wait_req_a();
    exp_q.push_back(pk(2'd1, 12'd33, 16'd0));
    rel(2'd1, 1'b1, 16'd0);
    rel(2'd0, 1'b0, 16'd2);
    chk_cnt("during_req", 12'd34, 16'd518, 12'd33, 16'd0, 12'd0, 16'd0);
    ack_en = 1'b1;
    settle_a();

    // Release on the ack cycle keeps the class pending
    ack_en = 1'b0;
    exp_q.push_back(pk(2'd1, 12'd34, 16'd0));
    rel(2'd1, 1'b1, 16'd0);
    wait_req_a();
    ack_man = 1'b1;
    rel(2'd1, 1'b1, 16'd0);
    ack_man = 1'b0;
    exp_q.push_back(pk(2'd1, 12'd35, 16'd0));
    chk("np_hdr_setwins", 32'(np_hdr), 32'd35);
    ack_en = 1'b1;
    settle_a();

    // Data counter wrap
    exp_q.push_back(pk(2'd0, 12'd34, 16'd65534));
    rel(2'd0, 1'b0, 16'd65016);
    chk("p_data_max", 32'(p_data), 32'd65534);
    settle_a();
    exp_q.push_back(pk(2'd0, 12'd34, 16'd2));
    rel(2'd0, 1'b0, 16'd4);
    chk("p_data_wrap", 32'(p_data), 32'd2);
    settle_a();

    // Infinite fields and class 11 change nothing and raise no request
    rel(2'd2, 1'b1, 16'd5);
    rel(2'd3, 1'b1, 16'd7);
    rel(2'd1, 1'b0, 16'd9);
    chk_cnt("ignored", 12'd34, 16'd2, 12'd35, 16'd0, 12'd0, 16'd0);
    repeat (10) step();
    chk("ignored_req", 32'(updatefc_req), 32'd0);

    // Timer-driven refresh: P then NP, never CPL
    exp8_q.push_back(pk(2'd0, 12'd32, 16'd512));
    exp8_q.push_back(pk(2'd1, 12'd32, 16'd0));
    rst8_n = 1'b1;
    settle_8();
    ack8_en = 1'b0;
    exp8_q.push_back(pk(2'd0, 12'd32, 16'd512));
    begin
      int k = 0;
      while ((exp8_q.size() != 0 || !req8) && k < 40) begin
        step();
        k++;
      end
    end
    chk("req8_held", 32'(req8), 32'd1);

    // Reset while requesting drops the request without an ack
    rst8_n = 1'b0;
    step();
    chk("req8_after_rst", 32'(req8), 32'd0);
    chk("req8_payload_rst", 32'({typ8, hdr8, data8}), 32'd0);
    chk("cnt8_rst", 32'({p_hdr8, np_hdr8}), 32'({12'd32, 12'd32}));
    chk("cnt8_rst_data", 32'({p_data8, np_data8}), 32'({16'd512, 16'd0}));
    chk("cnt8_rst_cpl", 32'({cpl_hdr8, cpl_data8}), 32'd0);
    chk("scale8", 32'({t0, t1, t2, t3, t4, t5}), 32'h555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
